// File: rtl/avl_bus_arbiter.sv
// avl_bus_arbiter
//   Multiplexes MASTER_NUM master command streams onto one shared bus slave
//   port, accepting at most one command per cycle. It routes read responses
//   back to the issuing master in order, using a FIFO of master indices.
//
// Configuration macro:
//   AVL_ARB_FIXED_PRIO_EN  defined   -> fixed priority, lowest requesting index wins
//                          undefined -> round-robin starting from pointer prio
//
// Ports:
//   clk                  clock, all state on posedge
//   rest                 asynchronous active-low reset
//   m_address/byte_en/read/write/write_data   per-master command
//   m_request_ready      per-master command accepted (at most one bit set)
//   m_read_data          broadcast of s_read_data
//   m_read_data_valid    one-hot response valid for the FIFO-head master
//   m_resp_ready         per-master response accept
//   s_address/byte_en/read/write/write_data   forwarded command
//   s_request_ready      slave accepts command
//   s_read_data/_valid   slave response
//   s_resp_ready         response ready to slave (1 when nothing is outstanding)
//   rd_outstanding       outstanding-read FIFO occupancy
//   err_unexpected_resp  sticky: response arrived with no read outstanding
module avl_bus_arbiter #(
  parameter int unsigned MASTER_NUM    = 8,
  parameter int unsigned RD_FIFO_DEPTH = 8
) (
  input  logic                              clk,
  input  logic                              rest,
  input  logic [MASTER_NUM-1:0][31:0]       m_address,
  input  logic [MASTER_NUM-1:0][3:0]        m_byte_en,
  input  logic [MASTER_NUM-1:0]             m_read,
  input  logic [MASTER_NUM-1:0]             m_write,
  input  logic [MASTER_NUM-1:0][31:0]       m_write_data,
  output logic [MASTER_NUM-1:0]             m_request_ready,
  output logic [MASTER_NUM-1:0][31:0]       m_read_data,
  output logic [MASTER_NUM-1:0]             m_read_data_valid,
  input  logic [MASTER_NUM-1:0]             m_resp_ready,
  output logic [31:0]                       s_address,
  output logic [3:0]                        s_byte_en,
  output logic                              s_read,
  output logic                              s_write,
  output logic [31:0]                       s_write_data,
  input  logic                              s_request_ready,
  input  logic [31:0]                       s_read_data,
  input  logic                              s_read_data_valid,
  output logic                              s_resp_ready,
  output logic [$clog2(RD_FIFO_DEPTH):0]    rd_outstanding,
  output logic                              err_unexpected_resp
);

  localparam int unsigned IW = $clog2(MASTER_NUM);
  localparam int unsigned AW = $clog2(RD_FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned SW = IW + 1;

  logic [MASTER_NUM-1:0] req;
  logic                  gnt_valid;
  logic [IW-1:0]         gnt_idx;
  logic                  gnt_read;
  logic                  accept;
  logic                  push;
  logic                  pop;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [IW-1:0]         head;
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [CW-1:0]         count;
  logic [IW-1:0]         fifo_mem [RD_FIFO_DEPTH];

  assign req = m_read | m_write;

`ifdef AVL_ARB_FIXED_PRIO_EN
  // Scan from the top down so the lowest requesting index is the last write.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    for (int unsigned i = MASTER_NUM; i > 0; i--) begin
      if (req[i-1]) begin
        gnt_valid = 1'b1;
        gnt_idx   = IW'(i - 1);
      end
    end
  end
`else
  logic [IW-1:0] prio;
  logic [SW-1:0] scan;

  // Scan offsets from farthest to nearest; the requester closest to prio
  // (going upward, wrapping) is the last write and therefore wins.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    scan      = '0;
    for (int unsigned off = MASTER_NUM; off > 0; off--) begin
      scan = {1'b0, prio} + SW'(off - 1);
      if (scan >= SW'(MASTER_NUM)) scan = scan - SW'(MASTER_NUM);
      if (req[scan[IW-1:0]]) begin
        gnt_valid = 1'b1;
        gnt_idx   = scan[IW-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rest) begin
    if (!rest) begin
      prio <= '0;
    end else if (accept) begin
      prio <= (gnt_idx == IW'(MASTER_NUM - 1)) ? '0 : gnt_idx + IW'(1);
    end
  end
`endif

  // Read wins when a master raises both read and write.
  assign gnt_read   = gnt_valid & m_read[gnt_idx];
  assign fifo_empty = (count == '0);
  assign fifo_full  = count[AW];

  always_comb begin
    s_address    = '0;
    s_byte_en    = '0;
    s_write_data = '0;
    s_read       = 1'b0;
    s_write      = 1'b0;
    if (gnt_valid) begin
      s_address    = m_address[gnt_idx];
      s_byte_en    = m_byte_en[gnt_idx];
      s_write_data = m_write_data[gnt_idx];
      s_read       = gnt_read & ~fifo_full;
      s_write      = ~gnt_read;
    end
  end

  // A read stalled by a full FIFO keeps the grant; no other master slips in.
  assign accept = gnt_valid & s_request_ready & ~(gnt_read & fifo_full);
  assign push   = accept & gnt_read;

  always_comb begin
    m_request_ready = '0;
    if (accept) m_request_ready[gnt_idx] = 1'b1;
  end

  assign head         = fifo_mem[rd_ptr];
  assign s_resp_ready = fifo_empty ? 1'b1 : m_resp_ready[head];
  assign pop          = s_read_data_valid & s_resp_ready & ~fifo_empty;
  assign m_read_data  = {MASTER_NUM{s_read_data}};

  always_comb begin
    m_read_data_valid = '0;
    if (s_read_data_valid && !fifo_empty) m_read_data_valid[head] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= gnt_idx;
  end

  always_ff @(posedge clk or negedge rest) begin
    if (!rest) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rest) begin
    if (!rest) begin
      err_unexpected_resp <= 1'b0;
    end else if (s_read_data_valid && fifo_empty) begin
      err_unexpected_resp <= 1'b1;
    end
  end

  assign rd_outstanding = count;

endmodule

// File: tb/tb_avl_bus_arbiter.sv
module tb_avl_bus_arbiter;

  localparam int N = 8;
  localparam int D = 8;

  logic                 clk;
  logic                 rest;
  logic [N-1:0][31:0]   m_address;
  logic [N-1:0][3:0]    m_byte_en;
  logic [N-1:0]         m_read;
  logic [N-1:0]         m_write;
  logic [N-1:0][31:0]   m_write_data;
  logic [N-1:0]         m_request_ready;
  logic [N-1:0][31:0]   m_read_data;
  logic [N-1:0]         m_read_data_valid;
  logic [N-1:0]         m_resp_ready;
  logic [31:0]          s_address;
  logic [3:0]           s_byte_en;
  logic                 s_read;
  logic                 s_write;
  logic [31:0]          s_write_data;
  logic                 s_request_ready;
  logic [31:0]          s_read_data;
  logic                 s_read_data_valid;
  logic                 s_resp_ready;
  logic [$clog2(D):0]   rd_outstanding;
  logic                 err_unexpected_resp;

  avl_bus_arbiter #(.MASTER_NUM(N), .RD_FIFO_DEPTH(D)) dut (
    .clk(clk), .rest(rest),
    .m_address(m_address), .m_byte_en(m_byte_en), .m_read(m_read),
    .m_write(m_write), .m_write_data(m_write_data),
    .m_request_ready(m_request_ready), .m_read_data(m_read_data),
    .m_read_data_valid(m_read_data_valid), .m_resp_ready(m_resp_ready),
    .s_address(s_address), .s_byte_en(s_byte_en), .s_read(s_read),
    .s_write(s_write), .s_write_data(s_write_data),
    .s_request_ready(s_request_ready), .s_read_data(s_read_data),
    .s_read_data_valid(s_read_data_valid), .s_resp_ready(s_resp_ready),
    .rd_outstanding(rd_outstanding), .err_unexpected_resp(err_unexpected_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference model: queue of issuing masters, rotating priority, sticky error.
  int unsigned mq[$];
  int unsigned mprio;
  bit          merr;

  initial begin : model
    bit          gv, is_rd, full, empty, acc, srr, rdv;
    int unsigned g, hd, i;
    mprio = 0;
    merr  = 0;
    forever begin
      @(negedge clk);
      if (!rest) begin
        mq.delete();
        mprio = 0;
        merr  = 0;
        chk("rst_outstanding", rd_outstanding, 0);
        chk("rst_err", err_unexpected_resp, 0);
        chk("rst_s_resp_ready", s_resp_ready, 1);
        chk("rst_m_rdv", m_read_data_valid, 0);
      end else begin
        gv = 0;
        g  = 0;
        for (int k = 0; k < N; k++) begin
`ifdef AVL_ARB_FIXED_PRIO_EN
          i = k;
`else
          i = (mprio + k) % N;
`endif
          if (!gv && (m_read[i] || m_write[i])) begin
            gv = 1;
            g  = i;
          end
        end
        is_rd = gv && m_read[g];
        full  = (mq.size() == D);
        empty = (mq.size() == 0);
        acc   = gv && s_request_ready && !(is_rd && full);
        hd    = empty ? 0 : mq[0];
        srr   = empty ? 1'b1 : m_resp_ready[hd];
        rdv   = s_read_data_valid && !empty;

        chk("m_request_ready", m_request_ready, acc ? (64'd1 << g) : 64'd0);
        chk("s_read", s_read, gv && is_rd && !full);
        chk("s_write", s_write, gv && !is_rd);
        if (gv) begin
          chk("s_address", s_address, m_address[g]);
          chk("s_byte_en", s_byte_en, m_byte_en[g]);
          chk("s_write_data", s_write_data, m_write_data[g]);
        end
        chk("s_resp_ready", s_resp_ready, srr);
        chk("m_read_data_valid", m_read_data_valid, rdv ? (64'd1 << hd) : 64'd0);
        if (rdv) chk("m_read_data", m_read_data[hd], s_read_data);
        chk("rd_outstanding", rd_outstanding, mq.size());
        chk("err_unexpected_resp", err_unexpected_resp, merr);

        if (s_read_data_valid && empty) merr = 1;
        if (s_read_data_valid && srr && !empty) void'(mq.pop_front());
        if (acc && is_rd) mq.push_back(g);
        if (acc) mprio = (g + 1) % N;
      end
    end
  end

  task automatic idle_inputs();
    m_address         = '0;
    m_byte_en         = '0;
    m_read            = '0;
    m_write           = '0;
    m_write_data      = '0;
    m_resp_ready      = '1;
    s_request_ready   = 1'b0;
    s_read_data       = '0;
    s_read_data_valid = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Leaves the caller just after a posedge with reset released and inputs idle.
  task automatic do_reset();
    next_cycle();
    rest = 1'b0;
    idle_inputs();
    next_cycle();
    next_cycle();
    rest = 1'b1;
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : stim
    int unsigned t1_exp[5];
    int unsigned t3_m[3];
    logic [31:0] t3_a[3];
    logic [31:0] t3_d[3];
    int unsigned r;

    t1_exp = '{0, 3, 5, 0, 3};
    t3_m   = '{1, 6, 1};
    t3_a   = '{32'h10, 32'h20, 32'h30};
    t3_d   = '{32'hA, 32'hB, 32'hC};

    idle_inputs();
    rest = 1'b1;
    #1 rest = 1'b0;
    @(negedge clk);
    chk("reset_outstanding", rd_outstanding, 0);
    chk("reset_s_resp_ready", s_resp_ready, 1);
    chk("reset_s_read", s_read, 0);
    chk("reset_s_write", s_write, 0);

    // Round-robin among writers 0, 3, 5.
    do_reset();
    s_request_ready = 1'b1;
    m_write = 8'b0010_1001;
    for (int k = 0; k < N; k++) m_address[k] = 32'(k * 16);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("t1_grant", m_request_ready, 64'd1 << t1_exp[k]);
      chk("t1_onehot", $countones(m_request_ready), 1);
      next_cycle();
    end

    // FIFO full blocking with master 2.
    do_reset();
    s_request_ready = 1'b1;
    m_read[2]       = 1'b1;
    m_address[2]    = 32'h100;
    for (int k = 0; k < D; k++) begin
      @(negedge clk);
      chk("t2_accept", m_request_ready, 8'h04);
      next_cycle();
    end
    @(negedge clk);
    chk("t2_full_occ", rd_outstanding, 8);
    chk("t2_full_s_read", s_read, 0);
    chk("t2_full_block", m_request_ready, 0);
    next_cycle();
    s_read_data_valid = 1'b1;
    s_read_data       = 32'h55;
    @(negedge clk);
    chk("t2_pop_cycle_block", m_request_ready, 0);
    chk("t2_pop_valid", m_read_data_valid, 8'h04);
    next_cycle();
    s_read_data_valid = 1'b0;
    @(negedge clk);
    chk("t2_occ_after_pop", rd_outstanding, 7);
    chk("t2_ninth_accept", m_request_ready, 8'h04);
    next_cycle();
    idle_inputs();
    @(negedge clk);
    chk("t2_refilled", rd_outstanding, 8);

    // In-order response routing, 3-cycle latency.
    do_reset();
    s_request_ready = 1'b1;
    for (int c = 0; c < 7; c++) begin
      m_read = '0;
      s_read_data_valid = 1'b0;
      if (c < 3) begin
        m_read[t3_m[c]]    = 1'b1;
        m_address[t3_m[c]] = t3_a[c];
      end
      if (c >= 3 && c < 6) begin
        s_read_data_valid = 1'b1;
        s_read_data       = t3_d[c-3];
      end
      @(negedge clk);
      if (c < 3) begin
        chk("t3_addr", s_address, t3_a[c]);
        chk("t3_accept", m_request_ready, 64'd1 << t3_m[c]);
      end
      if (c >= 3 && c < 6) begin
        chk("t3_valid", m_read_data_valid, 64'd1 << t3_m[c-3]);
        chk("t3_data", m_read_data[t3_m[c-3]], t3_d[c-3]);
      end
      next_cycle();
    end
    @(negedge clk);
    chk("t3_drained", rd_outstanding, 0);

    // Response backpressure from master 4.
    do_reset();
    s_request_ready = 1'b1;
    m_read[4]       = 1'b1;
    m_address[4]    = 32'h40;
    @(negedge clk);
    chk("t4_accept", m_request_ready, 8'h10);
    next_cycle();
    m_read            = '0;
    m_resp_ready[4]   = 1'b0;
    s_read_data_valid = 1'b1;
    s_read_data       = 32'h44;
    @(negedge clk);
    chk("t4_s_resp_ready_low", s_resp_ready, 0);
    chk("t4_valid", m_read_data_valid, 8'h10);
    chk("t4_occ_pending", rd_outstanding, 1);
    next_cycle();
    @(negedge clk);
    chk("t4_occ_held", rd_outstanding, 1);
    next_cycle();
    m_resp_ready[4] = 1'b1;
    @(negedge clk);
    chk("t4_s_resp_ready_high", s_resp_ready, 1);
    next_cycle();
    s_read_data_valid = 1'b0;
    @(negedge clk);
    chk("t4_occ_popped", rd_outstanding, 0);

    // Unexpected response error, sticky until reset.
    do_reset();
    s_read_data_valid = 1'b1;
    @(negedge clk);
    chk("t5_err_before", err_unexpected_resp, 0);
    chk("t5_drain_ready", s_resp_ready, 1);
    next_cycle();
    s_read_data_valid = 1'b0;
    @(negedge clk);
    chk("t5_err_set", err_unexpected_resp, 1);
    next_cycle();
    next_cycle();
    @(negedge clk);
    chk("t5_err_sticky", err_unexpected_resp, 1);
    next_cycle();
    rest = 1'b0;
    #2;
    chk("t5_err_async_clear", err_unexpected_resp, 0);
    next_cycle();
    rest = 1'b1;

    // Masters 2 and 7 both requesting continuously.
    do_reset();
    s_request_ready = 1'b1;
    m_write[2]      = 1'b1;
    m_write[7]      = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
`ifdef AVL_ARB_FIXED_PRIO_EN
      chk("t6_fixed", m_request_ready, 8'h04);
`else
      chk("t6_alternate", m_request_ready, (k % 2 == 1) ? 8'h80 : 8'h04);
`endif
      next_cycle();
    end

    // Randomized traffic against the model, including a reset mid-traffic.
    do_reset();
    for (int it = 0; it < 3000; it++) begin
      if (it == 1500) do_reset();
      for (int i = 0; i < N; i++) begin
        r = $urandom_range(0, 9);
        m_read[i]       = (r < 2) || (r == 9);
        m_write[i]      = (r >= 2 && r < 4) || (r == 9);
        m_address[i]    = $urandom;
        m_byte_en[i]    = 4'($urandom);
        m_write_data[i] = $urandom;
        m_resp_ready[i] = ($urandom_range(0, 3) != 0);
      end
      s_request_ready   = ($urandom_range(0, 3) != 0);
      s_read_data_valid = ($urandom_range(0, 2) == 0);
      s_read_data       = $urandom;
      @(negedge clk);
      next_cycle();
    end

    idle_inputs();
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/avl_bus_arbiter.md
Name: avl_bus_arbiter

Overview:
- Sits directly upstream of a shared i_avl_bus slave port and multiplexes MASTER_NUM master command streams onto it.
- Guarantees at most one command is accepted per cycle.
- Routes read responses back to the issuing master in order, using an outstanding-read FIFO of master indices.
- Its master side is the point where bus monitors attach.

Parameters:
- MASTER_NUM, 8, number of master ports (2..16).
- RD_FIFO_DEPTH, 8, maximum outstanding reads (power of 2, ≥2).

Ports:
- clk  in  1  clock, all state on posedge.
- rest  in  1  asynchronous active-low reset.
- m_address  in  MASTER_NUM x 32  per-master address.
- m_byte_en  in  MASTER_NUM x 4  per-master byte enables.
- m_read  in  MASTER_NUM  per-master read request.
- m_write  in  MASTER_NUM  per-master write request.
- m_write_data  in  MASTER_NUM x 32  per-master write data.
- m_request_ready  out  MASTER_NUM  command accepted this cycle.
- m_read_data  out  MASTER_NUM x 32  read data (broadcast of s_read_data).
- m_read_data_valid  out  MASTER_NUM  response valid, one-hot or zero.
- m_resp_ready  in  MASTER_NUM  master accepts response.
- s_address / s_byte_en / s_read / s_write / s_write_data  out  32/4/1/1/32  forwarded command.
- s_request_ready  in  1  slave accepts command.
- s_read_data  in  32  slave read data.
- s_read_data_valid  in  1  slave response valid.
- s_resp_ready  out  1  response ready to slave.
- rd_outstanding  out  $clog2(RD_FIFO_DEPTH)+1  current FIFO occupancy.
- err_unexpected_resp  out  1  sticky, response with empty FIFO.

Behaviour:
- Request of master i: req[i] = m_read[i] | m_write[i]. m_read and m_write both high is illegal; the arbiter forwards it as a read.
- Arbitration (combinational):
  - Round-robin from pointer prio (reset 0).
  - grant = first i with req[i], scanning prio, prio+1, … modulo MASTER_NUM.
  - No request → no grant.
- Forwarding (zero latency): s_* = m_* of the granted master; s_read = s_write = 0 when there is no grant.
- Blocking when full: if the FIFO is full and the granted master requests a read, s_read is forced 0. The grant does not move to another master that cycle.
- Acceptance: accept = grant valid & s_request_ready & ~(read & fifo_full).
  - m_request_ready[grant] = accept; all other bits 0.
  - At most one bit high in any cycle.
- On accept: prio <= (grant+1) mod MASTER_NUM. No accept → prio holds.
- On an accepted read: push the grant index into the FIFO. Writes push nothing.
- Response routing:
  - head = FIFO front.
  - m_read_data_valid[head] = s_read_data_valid & ~empty.
  - s_resp_ready = m_resp_ready[head] when not empty; 1 when empty, so stray data is drained.
  - Pop on s_read_data_valid & s_resp_ready & ~empty.
- Simultaneous push and pop:
  - Not full: both happen, occupancy unchanged.
  - Full: push is blocked by the acceptance rule even if a pop occurs that cycle.
- Pointers wrap modulo RD_FIFO_DEPTH. Occupancy is an extra-bit counter, 0..RD_FIFO_DEPTH.
- err_unexpected_resp: set when s_read_data_valid & empty; cleared only by reset.
- Reset (async assert, posedge-synchronous release):
  - prio=0, FIFO empty, rd_outstanding=0, err=0.
  - All combinational outputs resolve to 0 except s_resp_ready=1.
  - Reset mid-transaction discards outstanding reads; later responses flag err.
- m_read_data = s_read_data for all masters; valid qualifies it.

Optional Feature:
- Macro: AVL_ARB_FIXED_PRIO_EN.
- Defined: fixed priority, lowest asserted index wins; prio register absent.
- Undefined: round-robin as above.
- All other behaviour is identical either way.

Test Plan:
- Masters 0, 3, 5 hold m_write with s_request_ready=1 from reset → grants 0, 3, 5, 0, 3 on consecutive cycles; exactly one m_request_ready bit per cycle.
- Master 2 issues 8 reads with the slave never responding (RD_FIFO_DEPTH=8) → 8 accepts, rd_outstanding=8; 9th read: s_read=0, m_request_ready=0. One response → pop, 9th accepted next cycle.
- Reads from masters 1, 6, 1 to addresses 0x10, 0x20, 0x30; slave returns 0xA, 0xB, 0xC with 3-cycle latency → m_read_data_valid one-hot 1, 6, 1 in order, data 0xA, 0xB, 0xC.
- Master 4 holds m_resp_ready=0 while a response is pending → s_resp_ready=0, FIFO holds; release → pop, rd_outstanding decrements by 1.
- s_read_data_valid=1 with empty FIFO → err_unexpected_resp=1, stays high; rest low → 0.
- With AVL_ARB_FIXED_PRIO_EN, masters 2 and 7 requesting continuously → master 2 wins every cycle. Without the macro they alternate 2, 7.
